// File: rtl/fp_to_int.sv
// Two-stage FP32 -> int32/uint32 converter (round toward zero) with valid/ready on both sides.
// Stage 1 decodes the operand and aligns the magnitude; stage 2 saturates, negates and raises flags.
module fp_to_int #(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_unsigned,
  input  logic [31:0]      i_a,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic             o_invalid,
  output logic             o_inexact,
  output logic [TAG_W-1:0] o_tag
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic             sign;
    logic             uns;
    logic             nan;
    logic             inf;
    logic             ge31;      // E >= 31
    logic             ge32;      // E >= 32
    logic             e31_exact; // E == 31 and frac == 0
    logic             nonneg;    // E >= 0, i.e. integer part nonzero
    logic             sticky;
    logic [31:0]      mag;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic [STAGES:1]   r_vld_pipe;
  s1_t               r_s1;
  s1_t               w_s1;
  logic              w_en;
  logic [7:0]        w_exp;
  logic [22:0]       w_frac;
  logic [23:0]       w_mant;
  logic signed [8:0] w_e;
  logic [4:0]        w_rsh;
  logic [4:0]        w_lsh;
  logic [31:0]       w_mask;
  logic [31:0]       w_res;
  logic              w_nv;
  logic              w_nx;

  assign w_en    = !o_valid || i_ready;
  assign o_ready = w_en;
  assign o_valid = r_vld_pipe[STAGES];

  assign w_exp  = i_a[30:23];
  assign w_frac = i_a[22:0];
  assign w_mant = {1'b1, w_frac};
  assign w_e    = $signed({1'b0, w_exp}) - 9'sd127;
  assign w_rsh  = 5'd23 - w_e[4:0];
  assign w_lsh  = w_e[4:0] - 5'd23;
  assign w_mask = (32'h1 << w_rsh) - 32'h1;

  always_comb begin
    w_s1           = '0;
    w_s1.sign      = i_a[31];
    w_s1.uns       = i_unsigned;
    w_s1.tag       = i_tag;
    w_s1.nan       = (w_exp == 8'hFF) && (w_frac != '0);
    w_s1.inf       = (w_exp == 8'hFF) && (w_frac == '0);
    w_s1.ge31      = (w_e >= 9'sd31);
    w_s1.ge32      = (w_e >= 9'sd32);
    w_s1.e31_exact = (w_e == 9'sd31) && (w_frac == '0);
    w_s1.nonneg    = (w_e >= 9'sd0);
    if (w_e < 9'sd0) begin
      // Pure fraction (incl. denormals): only exact zero is exact.
      w_s1.sticky = (w_exp != '0) || (w_frac != '0);
    end else if (w_e < 9'sd23) begin
      w_s1.mag    = {8'b0, w_mant} >> w_rsh;
      w_s1.sticky = |({8'b0, w_mant} & w_mask);
    end else if (w_e <= 9'sd31) begin
      w_s1.mag    = {8'b0, w_mant} << w_lsh;
    end
  end

  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    if (!r_s1.uns) begin
      if (r_s1.nan || (r_s1.inf && !r_s1.sign)) begin
        w_res = 32'h7FFF_FFFF;
        w_nv  = 1'b1;
      end else if (r_s1.inf) begin
        w_res = 32'h8000_0000;
        w_nv  = 1'b1;
      end else if (r_s1.ge31) begin
        // -2^31 is the only representable value at this exponent.
        w_res = r_s1.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_nv  = !(r_s1.sign && r_s1.e31_exact);
      end else begin
        w_res = r_s1.sign ? -r_s1.mag : r_s1.mag;
      end
    end else begin
      if (r_s1.nan || (!r_s1.sign && (r_s1.inf || r_s1.ge32))) begin
        w_res = 32'hFFFF_FFFF;
        w_nv  = 1'b1;
      end else if (r_s1.sign && r_s1.nonneg) begin
        w_nv  = 1'b1;
      end else if (!r_s1.sign) begin
        w_res = r_s1.mag;
      end
    end
    w_nx = r_s1.sticky && !w_nv;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      o_result   <= '0;
      o_invalid  <= 1'b0;
      o_inexact  <= 1'b0;
      o_tag      <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_valid};
      if (r_vld_pipe[1]) begin
        o_result  <= w_res;
        o_invalid <= w_nv;
        o_inexact <= w_nx;
        o_tag     <= r_s1.tag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_en && i_valid) r_s1 <= w_s1;
  end

endmodule
